bwt_merge_stream: RTL and testbench



---
 rtl/bwt_merge_stream_pkg.sv | 19 +
 rtl/bwt_merge_stream_if.sv | 28 ++
 rtl/bwt_merge_stream_row_compare.sv | 62 ++++++
 rtl/bwt_merge_stream.sv | 163 ++++++++++++++++
 tb/tb_bwt_merge_stream.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bwt_merge_stream_pkg.sv
// Shared BWT definitions: byte width, merge FSM state encoding and a key-index width helper.
package bwt_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MERGE   = 3'd1,
    DRAIN_A = 3'd2,
    DRAIN_B = 3'd3,
    DONE    = 3'd4
  } bwt_state_e;

  // Width of a column index; never zero so single-column rows still get a legal port.
  function automatic int key_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bwt_merge_stream_if.sv
// FIFO-side bundle of the merge unit: two first-word-fall-through input runs and one output FIFO.
interface bwt_merge_stream_if
  import bwt_pkg::*;
#(
  parameter int COLUMN = 3
);

  logic [COLUMN-1:0][BYTE_W-1:0] a_data;
  logic                          a_empty;
  logic                          a_rd;
  logic [COLUMN-1:0][BYTE_W-1:0] b_data;
  logic                          b_empty;
  logic                          b_rd;
  logic [COLUMN-1:0][BYTE_W-1:0] out_data;
  logic                          out_wr;
  logic                          out_full;

  modport master (
    input  a_data, a_empty, b_data, b_empty, out_full,
    output a_rd, b_rd, out_data, out_wr
  );

  modport slave (
    output a_data, a_empty, b_data, b_empty, out_full,
    input  a_rd, b_rd, out_data, out_wr
  );

endinterface

// File: rtl/bwt_merge_stream_row_compare.sv
// Cyclic multi-byte key compare: first differing byte from key_start (mod COLUMN) decides, ties pick A.
// BWT_MERGE_DESC_EN adds a desc input that makes the larger key win.
module bwt_row_compare
  import bwt_pkg::*;
#(
  parameter  int COLUMN  = 3,
  parameter  int KEY_LEN = 3,
  localparam int KS_W    = key_idx_w(COLUMN)
) (
  input  logic [COLUMN-1:0][BYTE_W-1:0] row_a,
  input  logic [COLUMN-1:0][BYTE_W-1:0] row_b,
  input  logic [KS_W-1:0]               key_start,
`ifdef BWT_MERGE_DESC_EN
  input  logic                          desc,
`endif
  output logic                          sel_a
);

  logic [KEY_LEN-1:0] a_lt;
  logic [KEY_LEN-1:0] a_gt;
  logic               desc_i;

`ifdef BWT_MERGE_DESC_EN
  assign desc_i = desc;
`else
  assign desc_i = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < KEY_LEN; gi++) begin : g_key
      logic [BYTE_W-1:0] byte_a;
      logic [BYTE_W-1:0] byte_b;

      // Mux by constant column index so the rotated select stays width-clean.
      always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int c = 0; c < COLUMN; c++) begin
          if (((int'(key_start) + gi) % COLUMN) == c) begin
            byte_a = row_a[c];
            byte_b = row_b[c];
          end
        end
      end

      assign a_lt[gi] = (byte_a < byte_b);
      assign a_gt[gi] = (byte_a > byte_b);
    end
  endgenerate

  // Scan from the last key byte down so the lowest differing byte has the final say.
  always_comb begin
    sel_a = 1'b1;
    for (int k = KEY_LEN - 1; k >= 0; k--) begin
      if (a_lt[k] || a_gt[k]) begin
        sel_a = desc_i ? a_gt[k] : a_lt[k];
      end
    end
  end

endmodule

// File: rtl/bwt_merge_stream.sv
// Streaming two-way merge of two sorted FIFO runs into one output run, one row per cycle.
// Optional BWT_MERGE_DESC_EN adds a desc port selecting descending order.
module bwt_merge_stream
  import bwt_pkg::*;
#(
  parameter  int COLUMN  = 3,
  parameter  int KEY_LEN = 3,
  parameter  int RUN_W   = 8,
  localparam int KS_W    = key_idx_w(COLUMN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic [KS_W-1:0]  key_start,
`ifdef BWT_MERGE_DESC_EN
  input  logic             desc,
`endif
  bwt_merge_stream_if.master io,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_MERGE   = MERGE;
  localparam logic [2:0] ST_DRAIN_A = DRAIN_A;
  localparam logic [2:0] ST_DRAIN_B = DRAIN_B;
  localparam logic [2:0] ST_DONE    = DONE;

  logic [2:0]                    state_q, state_d;
  logic [RUN_W-1:0]              run_len_q, run_len_d;
  logic [KS_W-1:0]               key_start_q, key_start_d;
  logic [RUN_W-1:0]              cnt_a_q, cnt_a_d;
  logic [RUN_W-1:0]              cnt_b_q, cnt_b_d;
  logic [COLUMN-1:0][BYTE_W-1:0] out_data_q, out_data_d;
  logic                          out_wr_q, out_wr_d;
  logic                          done_q, done_d;
  logic                          desc_q, desc_d;

  logic             sel_a;
  logic             pop_a;
  logic             pop_b;
  logic [RUN_W-1:0] cnt_a_inc;
  logic [RUN_W-1:0] cnt_b_inc;

  bwt_row_compare #(
    .COLUMN  (COLUMN),
    .KEY_LEN (KEY_LEN)
  ) u_cmp (
    .row_a     (io.a_data),
    .row_b     (io.b_data),
    .key_start (key_start_q),
`ifdef BWT_MERGE_DESC_EN
    .desc      (desc_q),
`endif
    .sel_a     (sel_a)
  );

  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    case (state_q)
      ST_MERGE: begin
        if (!io.a_empty && !io.b_empty && !io.out_full) begin
          pop_a = sel_a;
          pop_b = !sel_a;
        end
      end
      ST_DRAIN_A: pop_a = !io.a_empty && !io.out_full;
      ST_DRAIN_B: pop_b = !io.b_empty && !io.out_full;
      default: ;
    endcase
  end

  assign io.a_rd     = pop_a && !rst;
  assign io.b_rd     = pop_b && !rst;
  assign io.out_data = out_data_q;
  assign io.out_wr   = out_wr_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign cnt_a_inc   = cnt_a_q + 1'b1;
  assign cnt_b_inc   = cnt_b_q + 1'b1;

  // Run-end tests use the incremented count so the last pop moves the FSM on in the same cycle.
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    key_start_d = key_start_q;
    desc_d      = desc_q;
    cnt_a_d     = pop_a ? cnt_a_inc : cnt_a_q;
    cnt_b_d     = pop_b ? cnt_b_inc : cnt_b_q;
    out_wr_d    = pop_a || pop_b;
    out_data_d  = pop_a ? io.a_data : (pop_b ? io.b_data : out_data_q);
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_len_d   = run_len;
          key_start_d = (int'(key_start) >= COLUMN) ? '0 : key_start;
`ifdef BWT_MERGE_DESC_EN
          desc_d      = desc;
`else
          desc_d      = 1'b0;
`endif
          cnt_a_d     = '0;
          cnt_b_d     = '0;
          if (run_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        if (pop_a && (cnt_a_inc == run_len_q)) begin
          state_d = ST_DRAIN_B;
        end else if (pop_b && (cnt_b_inc == run_len_q)) begin
          state_d = ST_DRAIN_A;
        end
      end
      ST_DRAIN_A: begin
        if (pop_a && (cnt_a_inc == run_len_q)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN_B: begin
        if (pop_b && (cnt_b_inc == run_len_q)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_len_q   <= '0;
      key_start_q <= '0;
      desc_q      <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      out_data_q  <= '0;
      out_wr_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      key_start_q <= key_start_d;
      desc_q      <= desc_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      out_data_q  <= out_data_d;
      out_wr_q    <= out_wr_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_bwt_merge_stream.sv
// Directed bench for bwt_merge_stream: queue-modelled input FIFOs, per-cycle observation, immediate asserts.
module tb_bwt_merge_stream;
  import bwt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] run_len = 8'd0;
  logic [1:0] key_start = 2'd0;
`ifdef BWT_MERGE_DESC_EN
  logic       desc = 1'b0;
`endif
  logic       busy;
  logic       done;

  bwt_merge_stream_if #(.COLUMN(3)) io();

  bwt_merge_stream #(
    .COLUMN  (3),
    .KEY_LEN (3),
    .RUN_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .run_len   (run_len),
    .key_start (key_start),
`ifdef BWT_MERGE_DESC_EN
    .desc      (desc),
`endif
    .io        (io),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic        hold_b = 1'b0;
  logic        s_ra, s_rb, o_wr, o_done, o_busy;
  logic [23:0] o_data;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [23:0] row(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic drive_fifos();
    io.a_empty = (qa.size() == 0);
    io.a_data  = (qa.size() != 0) ? qa[0] : 24'h0;
    io.b_empty = hold_b || (qb.size() == 0);
    io.b_data  = (qb.size() != 0) ? qb[0] : 24'h0;
  endtask

  // Read strobes are sampled mid-cycle; registered outputs are sampled just after the edge.
  task automatic tick();
    @(negedge clk);
    s_ra = io.a_rd;
    s_rb = io.b_rd;
    @(posedge clk);
    #1;
    if (s_ra && qa.size() != 0) qa.delete(0);
    if (s_rb && qb.size() != 0) qb.delete(0);
    drive_fifos();
    o_wr   = io.out_wr;
    o_data = io.out_data;
    o_done = done;
    o_busy = busy;
    $display("t=%0t rd_a=%b rd_b=%b wr=%b data=%06h done=%b busy=%b",
             $time, s_ra, s_rb, o_wr, o_data, o_done, o_busy);
  endtask

  task automatic go(input logic [7:0] len, input logic [1:0] ks);
    run_len   = len;
    key_start = ks;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_basic();
    qa.delete();
    qb.delete();
    qa.push_back(row(1, 2, 3));
    qa.push_back(row(4, 0, 0));
    qb.push_back(row(2, 0, 0));
    qb.push_back(row(3, 9, 9));
    drive_fifos();
  endtask

  initial begin
    io.out_full = 1'b0;
    drive_fifos();

    // Reset state
    tick();
    tick();
    chk("reset_wr", o_wr, 0);
    chk("reset_data", o_data, 0);
    chk("reset_done", o_done, 0);
    chk("reset_busy", o_busy, 0);
    rst = 1'b0;
    tick();

    // Basic merge: A0, B0, B1, A1 on consecutive cycles, done with the last write
    load_basic();
    go(8'd2, 2'd0);
    tick();
    chk("basic_rd_a0", s_ra, 1);
    chk("basic_row0", o_data, row(1, 2, 3));
    chk("basic_wr0", o_wr, 1);
    chk("basic_busy", o_busy, 1);
    tick();
    chk("basic_rd_b0", s_rb, 1);
    chk("basic_row1", o_data, row(2, 0, 0));
    tick();
    chk("basic_row2", o_data, row(3, 9, 9));
    chk("basic_done_early", o_done, 0);
    tick();
    chk("basic_row3", o_data, row(4, 0, 0));
    chk("basic_wr3", o_wr, 1);
    chk("basic_done", o_done, 1);
    tick();
    chk("basic_done_pulse", o_done, 0);
    chk("basic_idle_busy", o_busy, 0);
    chk("basic_wr_after", o_wr, 0);

    // Tie: A is popped first, then B
    qa.push_back(row(5, 5, 5));
    qb.push_back(row(5, 5, 5));
    drive_fifos();
    go(8'd1, 2'd0);
    tick();
    chk("tie_first_a", {s_ra, s_rb}, 2'b10);
    chk("tie_row0", o_data, row(5, 5, 5));
    tick();
    chk("tie_then_b", {s_ra, s_rb}, 2'b01);
    chk("tie_done", o_done, 1);
    tick();

    // Wraparound key from column 2: A wins on col2 (1 < 2)
    qa.push_back(row(9, 0, 1));
    qb.push_back(row(0, 9, 2));
    drive_fifos();
    go(8'd1, 2'd2);
    tick();
    chk("wrap_sel", {s_ra, s_rb}, 2'b10);
    chk("wrap_row0", o_data, row(9, 0, 1));
    tick();
    chk("wrap_row1", o_data, row(0, 9, 2));
    chk("wrap_done", o_done, 1);
    tick();

    // Out-of-range key_start latches as 0: same rows, B wins on col0
    qa.push_back(row(9, 0, 1));
    qb.push_back(row(0, 9, 2));
    drive_fifos();
    go(8'd1, 2'd3);
    tick();
    chk("ks_clamp_sel", {s_ra, s_rb}, 2'b01);
    chk("ks_clamp_row0", o_data, row(0, 9, 2));
    tick();
    chk("ks_clamp_row1", o_data, row(9, 0, 1));
    tick();

    // Backpressure: three cycles of out_full mid-merge
    qa.push_back(row(1, 0, 0));
    qa.push_back(row(3, 0, 0));
    qb.push_back(row(2, 0, 0));
    qb.push_back(row(4, 0, 0));
    drive_fifos();
    go(8'd2, 2'd0);
    tick();
    chk("bp_row0", o_data, row(1, 0, 0));
    io.out_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_rd", {s_ra, s_rb}, 2'b00);
      chk("bp_no_wr", o_wr, 0);
      chk("bp_hold", o_data, row(1, 0, 0));
    end
    io.out_full = 1'b0;
    tick();
    chk("bp_row1", o_data, row(2, 0, 0));
    tick();
    chk("bp_row2", o_data, row(3, 0, 0));
    tick();
    chk("bp_row3", o_data, row(4, 0, 0));
    chk("bp_done", o_done, 1);
    tick();

    // Empty stall: B empty for 5 cycles, nothing popped
    qa.push_back(row(1, 0, 0));
    qb.push_back(row(7, 0, 0));
    hold_b = 1'b1;
    drive_fifos();
    go(8'd1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_rd", {s_ra, s_rb}, 2'b00);
      chk("stall_no_wr", o_wr, 0);
    end
    hold_b = 1'b0;
    drive_fifos();
    tick();
    chk("stall_rd_a", s_ra, 1);
    chk("stall_row0", o_data, row(1, 0, 0));
    tick();
    chk("stall_row1", o_data, row(7, 0, 0));
    chk("stall_done", o_done, 1);
    tick();

    // run_len = 0: done one cycle after start, no reads or writes
    qa.push_back(row(1, 1, 1));
    qb.push_back(row(2, 2, 2));
    drive_fifos();
    go(8'd0, 2'd0);
    chk("zero_done", o_done, 1);
    chk("zero_wr", o_wr, 0);
    tick();
    chk("zero_no_rd", {s_ra, s_rb}, 2'b00);
    chk("zero_done_pulse", o_done, 0);
    chk("zero_idle", o_busy, 0);

    // Reset mid-merge, then a fresh merge
    load_basic();
    go(8'd2, 2'd0);
    tick();
    chk("rstm_row0", o_data, row(1, 2, 3));
    rst = 1'b1;
    tick();
    chk("rstm_no_rd", {s_ra, s_rb}, 2'b00);
    chk("rstm_wr", o_wr, 0);
    chk("rstm_data", o_data, 0);
    chk("rstm_done", o_done, 0);
    chk("rstm_busy", o_busy, 0);
    rst = 1'b0;
    tick();
    chk("rstm_no_done", o_done, 0);
    load_basic();
    go(8'd2, 2'd0);
    tick();
    chk("fresh_row0", o_data, row(1, 2, 3));
    tick();
    chk("fresh_row1", o_data, row(2, 0, 0));
    tick();
    chk("fresh_row2", o_data, row(3, 9, 9));
    tick();
    chk("fresh_row3", o_data, row(4, 0, 0));
    chk("fresh_done", o_done, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
